vc_dest_router: RTL and testbench

//  Downstream neighbour of the VC0 pop-delay stage: arbitrates pops from the VC0/VC1 FIFOs
//  (VC0 strict priority), collects the FIFO read data one cycle after each pop, and routes

---
 rtl/vc_dest_router_pkg.sv | 8 +
 rtl/vc_pop_arbiter.sv | 15 +
 rtl/vc_dest_router.sv | 58 +++++
 tb/tb_vc_dest_router.sv | 110 +++++++++++
 4 files changed

// File: rtl/vc_dest_router_pkg.sv
// vc_dest_router_pkg: shared word layout and VC identifiers for the VC FIFO / router slice
package vc_dest_router_pkg;
  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_DEST_BIT = 4;
  localparam int DEF_VC_CLASS_BIT = 5;
  localparam int DEF_CNT_WIDTH = 5;
  typedef enum logic {VC_ID_0 = 1'b0, VC_ID_1 = 1'b1} vc_id_e;
endpackage

// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter: strict-priority pop request for the VC0/VC1 FIFOs, stalled by either almost-full
module vc_pop_arbiter (
  input  logic reset,
  input  logic vc0_empty,
  input  logic vc1_empty,
  input  logic d0_full,
  input  logic d1_full,
  output logic pop_vc0,
  output logic pop_vc1
);
  logic go;
  assign go = !reset & !(d0_full | d1_full);
  assign pop_vc0 = go & !vc0_empty;
  assign pop_vc1 = go & vc0_empty & !vc1_empty;
endmodule

// File: rtl/vc_dest_router.sv
// vc_dest_router: pops VC FIFOs, aligns read data one cycle later and pushes each word to D0/D1 by its dest bit
module vc_dest_router
  import vc_dest_router_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEST_BIT = DEF_DEST_BIT,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic [DATA_WIDTH-1:0] vc0_data,
  input  logic [DATA_WIDTH-1:0] vc1_data,
  input  logic                  d0_full,
  input  logic                  d1_full,
  output logic                  pop_vc0,
  output logic                  pop_vc1,
  output logic                  push_d0,
  output logic                  push_d1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_WIDTH-1:0]  cnt_d0,
  output logic [CNT_WIDTH-1:0]  cnt_d1,
  output logic                  idle
);
  logic valid1, valid2;
  vc_id_e sel1;
  vc_pop_arbiter u_arb (
    .reset(reset),
    .vc0_empty(vc0_empty),
    .vc1_empty(vc1_empty),
    .d0_full(d0_full),
    .d1_full(d1_full),
    .pop_vc0(pop_vc0),
    .pop_vc1(pop_vc1)
  );
  // Pushes are not gated by full: the almost-full margin absorbs the two words in flight.
  assign push_d0 = valid2 & !data_out[DEST_BIT];
  assign push_d1 = valid2 & data_out[DEST_BIT];
  assign idle = !valid1 & !valid2 & vc0_empty & vc1_empty;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid1 <= 1'b0;
      sel1 <= VC_ID_0;
      valid2 <= 1'b0;
      data_out <= '0;
      cnt_d0 <= '0;
      cnt_d1 <= '0;
    end else begin
      valid1 <= pop_vc0 | pop_vc1;
      sel1 <= pop_vc1 ? VC_ID_1 : VC_ID_0;
      valid2 <= valid1;
      if (valid1) data_out <= (sel1 == VC_ID_1) ? vc1_data : vc0_data;
      cnt_d0 <= cnt_d0 + CNT_WIDTH'(push_d0);
      cnt_d1 <= cnt_d1 + CNT_WIDTH'(push_d1);
    end
  end
endmodule

// File: tb/tb_vc_dest_router.sv
// tb_vc_dest_router: directed and random stimulus checked against a queue-based transaction model
module tb_vc_dest_router;
  logic clk = 0;
  logic reset, vc0_empty, vc1_empty, d0_full, d1_full;
  logic [5:0] vc0_data, vc1_data, data_out;
  logic pop_vc0, pop_vc1, push_d0, push_d1, idle;
  logic [4:0] cnt_d0, cnt_d1;
  int checks = 0, errors = 0, cyc = 0, n0 = 0, n1 = 0;
  logic [5:0] last = 0;
  typedef struct {int due; logic vc;} pop_t;
  typedef struct {int due; logic [5:0] w;} word_t;
  pop_t pq[$];
  word_t wq[$];
  always #5 clk = ~clk;
  vc_dest_router dut (
    .clk(clk), .reset(reset), .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data), .d0_full(d0_full), .d1_full(d1_full),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1), .push_d0(push_d0), .push_d1(push_d1),
    .data_out(data_out), .cnt_d0(cnt_d0), .cnt_d1(cnt_d1), .idle(idle)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  // One clock cycle: drive inputs, check every output against the model, then advance.
  task automatic step(input logic r, input logic v0e, input logic v1e, input logic f0, input logic f1,
                      input logic [5:0] w0, input logic [5:0] w1);
    logic p0, p1, hw;
    word_t cur;
    reset = r; vc0_empty = v0e; vc1_empty = v1e; d0_full = f0; d1_full = f1;
    vc0_data = w0; vc1_data = w1;
    if (r) begin pq.delete(); wq.delete(); n0 = 0; n1 = 0; last = 0; end
    #4;
    p0 = !r && !v0e && !(f0 || f1);
    p1 = !r && v0e && !v1e && !(f0 || f1);
    hw = wq.size() > 0 && wq[0].due == cyc;
    cur = hw ? wq[0] : '{0, last};
    chk("pop_vc0", pop_vc0, p0);
    chk("pop_vc1", pop_vc1, p1);
    chk("push_d0", push_d0, hw && !cur.w[4]);
    chk("push_d1", push_d1, hw && cur.w[4]);
    chk("data_out", data_out, cur.w);
    chk("cnt_d0", cnt_d0, n0 % 32);
    chk("cnt_d1", cnt_d1, n1 % 32);
    chk("idle", idle, pq.size() == 0 && wq.size() == 0 && v0e && v1e);
    if (hw) begin
      if (cur.w[4]) n1++; else n0++;
      last = cur.w;
      void'(wq.pop_front());
    end
    if (pq.size() > 0 && pq[0].due == cyc) begin
      wq.push_back('{cyc + 1, pq[0].vc ? w1 : w0});
      void'(pq.pop_front());
    end
    if (p0 || p1) pq.push_back('{cyc + 1, p1});
    @(posedge clk); #1;
    cyc++;
  endtask
  initial begin
    reset = 1; vc0_empty = 1; vc1_empty = 1; d0_full = 0; d1_full = 0; vc0_data = 0; vc1_data = 0;
    @(posedge clk); #1;
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 6'h01, 0);
    step(0, 1, 1, 0, 0, 6'h02, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 6'h0A, 6'h3F);
    step(0, 1, 0, 0, 0, 6'h0B, 6'h3F);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 6'b010011, 0);
    step(0, 1, 1, 0, 0, 0, 6'b000101);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("route_cnt_d0", cnt_d0, 1);
    chk("route_cnt_d1", cnt_d1, 1);
    chk("route_last", data_out, 6'b000101);
    step(0, 0, 1, 0, 0, 6'h21, 0);
    step(0, 0, 1, 0, 0, 6'h11, 0);
    step(0, 0, 1, 1, 0, 6'h02, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 6'h13, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) step(0, 0, 1, 0, 0, 6'($urandom) & 6'h2F, 0);
    step(0, 1, 1, 0, 0, 6'($urandom) & 6'h2F, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("wrap_cnt_d0", cnt_d0, 0);
    chk("wrap_cnt_d1", cnt_d1, 0);
    step(0, 0, 1, 0, 0, 6'h10, 0);
    step(1, 0, 1, 0, 0, 6'h10, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("midrst_idle", idle, 1);
    chk("midrst_cnt_d1", cnt_d1, 0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, 6'($urandom), 6'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
